// File: rtl/cla_pkg.sv
// Shared types for the carry-lookahead adder propagate/generate front end.
package cla_pkg;

    localparam int unsigned PG_WIDTH = 8;
    localparam int unsigned PG_TAG_W = 8;

    typedef struct packed {
        logic [PG_WIDTH-1:0] p;
        logic [PG_WIDTH-1:0] g;
        logic                cin;
        logic [PG_TAG_W-1:0] tag;
    } pg_beat_t;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/cla_skid_buffer.sv
// Two-entry valid/ready skid buffer: a main register driving the outputs plus one
// skid register that absorbs the beat accepted while the consumer stalls.
module cla_skid_buffer
    import cla_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  pg_beat_t in_data_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output pg_beat_t out_data_o
);

    skid_state_t state_q;
    pg_beat_t    main_q;
    pg_beat_t    skid_q;
    logic        accept;
    logic        emit;

    assign in_ready_o  = (state_q != StFull);
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_q;

    assign accept = in_valid_i & in_ready_o;
    assign emit   = out_valid_o & out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_q  <= in_data_i;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_q <= in_data_i;
                    end else if (accept) begin
                        skid_q  <= in_data_i;
                        state_q <= StFull;
                    end else if (emit) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    // The older beat leaves first; the skid beat moves up behind it.
                    if (emit) begin
                        main_q  <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: rtl/cla8_pg_stage.sv
// Registered propagate/generate stage of the 8-bit CLA: forms p/g per bit, tags each
// accepted beat and hands it to the carry stage through a skid buffer.
module cla8_pg_stage
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = PG_WIDTH,
    parameter int unsigned TAG_W = PG_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH-1:0] out_g,
    output logic             out_cin,
    output logic [TAG_W-1:0] out_tag,
    output logic             overflow_err
);

    logic [TAG_W-1:0] tag_q, tag_d;
    logic             stall_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             err_q, err_d;
    logic             stall;
    logic             accept;
    pg_beat_t         in_beat;
    pg_beat_t         out_beat;

    always_comb begin
        in_beat     = '0;
        in_beat.p   = in_a ^ in_b;
        in_beat.g   = in_a & in_b;
        in_beat.cin = in_cin;
        in_beat.tag = tag_q;
    end

    assign accept = in_valid & in_ready;
    assign stall  = in_valid & ~in_ready;

    always_comb begin
        tag_d = tag_q;
        if (accept) begin
            tag_d = tag_q + TAG_W'(1);
        end
    end

    // Upstream must hold its operands while stalled; a change between two stalled
    // cycles means a beat was silently dropped.
    always_comb begin
        err_d = err_q;
        if (stall && stall_q && ((in_a != a_q) || (in_b != b_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            stall_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            stall_q <= stall;
            a_q     <= in_a;
            b_q     <= in_b;
            err_q   <= err_d;
        end
    end

    cla_skid_buffer u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_beat),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_beat)
    );

    assign out_p        = out_beat.p;
    assign out_g        = out_beat.g;
    assign out_cin      = out_beat.cin;
    assign out_tag      = out_beat.tag;
    assign overflow_err = err_q;

endmodule

// File: tb/tb_cla8_pg_stage.sv
// Self-checking bench for cla8_pg_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_cla8_pg_stage;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] g;
        logic       cin;
        logic [7:0] tag;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_p;
    logic [7:0] out_g;
    logic       out_cin;
    logic [7:0] out_tag;
    logic       overflow_err;

    int checks = 0;
    int failures = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    tag_m = 0;

    always #5 clk = ~clk;

    cla8_pg_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_cin       (in_cin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_p        (out_p),
        .out_g        (out_g),
        .out_cin      (out_cin),
        .out_tag      (out_tag),
        .overflow_err (overflow_err)
    );

    // Reference model: every accepted operand pair becomes an expected beat in FIFO order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            obs_q.delete();
            tag_m = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back('{p: in_a ^ in_b, g: in_a & in_b, cin: in_cin,
                                  tag: 8'(tag_m)});
                tag_m = (tag_m + 1) % 256;
            end
            if (out_valid && out_ready)
                obs_q.push_back('{p: out_p, g: out_g, cin: out_cin, tag: out_tag});
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_p, out_g, out_cin, out_tag, overflow_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b p=%h g=%h c=%b t=%h e=%b expected all 0",
                     out_valid, out_p, out_g, out_cin, out_tag, overflow_err);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A; in_cin = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_p, out_g, out_cin, out_tag} !== {1'b1, 8'hFF, 8'h00, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL single_beat: got v=%b p=%h g=%h c=%b t=%h expected v=1 p=ff g=00 c=0 t=00",
                     out_valid, out_p, out_g, out_cin, out_tag);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01; in_cin = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready0: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_a = 8'h0F; in_b = 8'h0F; in_cin = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_p, out_g, out_cin, out_tag} !==
            {1'b1, 1'b1, 8'hFE, 8'h01, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL b2b_first: got r=%b v=%b p=%h g=%h c=%b t=%h expected r=1 v=1 p=fe g=01 c=1 t=00",
                     in_ready, out_valid, out_p, out_g, out_cin, out_tag);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_p, out_g, out_cin, out_tag} !==
            {1'b1, 1'b1, 8'h00, 8'h0F, 1'b0, 8'h01}) begin
            failures++;
            $display("FAIL b2b_second: got r=%b v=%b p=%h g=%h c=%b t=%h expected r=1 v=1 p=00 g=0f c=0 t=01",
                     in_ready, out_valid, out_p, out_g, out_cin, out_tag);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h31; in_b = 8'h13; in_cin = 1'b0;
        @(posedge clk); #1;
        in_a = 8'h42; in_b = 8'h24; in_cin = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_one: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_a = 8'h53; in_b = 8'h35;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_tag, out_p} !== {1'b0, 1'b1, 8'h00, 8'h22}) begin
            failures++;
            $display("FAIL bp_full: got r=%b v=%b t=%h p=%h expected r=0 v=1 t=00 p=22",
                     in_ready, out_valid, out_tag, out_p);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_tag, out_p, out_g} !== {1'b0, 1'b1, 8'h00, 8'h22, 8'h11}) begin
            failures++;
            $display("FAIL bp_stable: got r=%b v=%b t=%h p=%h g=%h expected r=0 v=1 t=00 p=22 g=11",
                     in_ready, out_valid, out_tag, out_p, out_g);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_tag} !== {1'b1, 8'h01}) begin
            failures++;
            $display("FAIL bp_second: got r=%b t=%h expected r=1 t=01", in_ready, out_tag);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            failures++;
            $display("FAIL bp_count: got obs=%0d exp=%0d expected 3", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || obs_q[i].tag !== 8'(i)) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got %h expected %h tag %0d", i, obs_q[i],
                             exp_q[i], i);
                end
            end
        end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 257 || exp_q.size() != 257) begin
            failures++;
            $display("FAIL wrap_count: got obs=%0d exp=%0d expected 257", obs_q.size(),
                     exp_q.size());
        end else begin
            for (int i = 0; i < 257; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || obs_q[i].tag !== 8'(i % 256)) begin
                    failures++;
                    $display("FAIL wrap_beat[%0d]: got %h expected %h tag %0d", i, obs_q[i],
                             exp_q[i], i % 256);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 8'h05}) begin
            failures++;
            $display("FAIL mid_full: got r=%b v=%b t=%h expected r=0 v=1 t=05",
                     in_ready, out_valid, out_tag);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, overflow_err, out_tag} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL mid_reset: got v=%b e=%b t=%h expected v=0 e=0 t=00",
                     out_valid, overflow_err, out_tag);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL mid_release: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'h0C; in_b = 8'h0A; in_cin = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_tag, out_p, out_g} !== {1'b1, 8'h00, 8'h06, 8'h08}) begin
            failures++;
            $display("FAIL mid_first_tag: got v=%b t=%h p=%h g=%h expected v=1 t=00 p=06 g=08",
                     out_valid, out_tag, out_p, out_g);
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02;
        @(posedge clk); #1;
        in_a = 8'h03;
        @(posedge clk); #1;
        in_a = 8'h11;
        @(posedge clk); #1;
        in_a = 8'h22;
        @(negedge clk);
        checks++;
        if ({in_ready, overflow_err} !== 2'b00) begin
            failures++;
            $display("FAIL err_before: got r=%b e=%b expected r=0 e=0", in_ready, overflow_err);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: got %b expected 1", overflow_err);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b expected 1", overflow_err);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared: got %b expected 0", overflow_err);
        end
    endtask

    task automatic test_random();
        logic hold;
        do_reset();
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            hold = in_valid && !in_ready;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size() || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL rand_count: got obs=%0d err=%b expected obs=%0d err=0",
                     obs_q.size(), overflow_err, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_tag_wrap();
        test_reset_mid();
        test_protocol_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
